// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer and status controller for the async FIFO.
// Owns the binary/Gray write pointer and derives full, almost-full, overflow and level.
module fifo_wr_ptr_ctrl #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned PTR_W  = 6
) (
    input  logic              wclk,
    input  logic              sw_rst,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] afull_value,
    input  logic [PTR_W-1:0]  rgray_sync,
    output logic              mem_we,
    output logic [ADDR_W-1:0] waddr,
    output logic [PTR_W-1:0]  wgray,
    output logic              wfull,
    output logic              wr_almost_ful,
    output logic              overflow,
    output logic [5:0]        fifo_write_count,
    output logic [PTR_W-1:0]  wr_level
);

    logic [PTR_W-1:0] wbin_q, wbin_d;
    logic [PTR_W-1:0] wgray_q, wgray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic [PTR_W-1:0] rbin;
    logic [5:0]       count_q, count_d;
    logic             wfull_q, wfull_d;
    logic             afull_q, afull_d;
    logic             overflow_q, overflow_d;
    logic             accept;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < int'(PTR_W); i++) begin
            rbin[i] = ^(rgray_sync >> i);
        end
    end

    always_comb begin
        accept     = write_enable & ~wfull_q & ~sw_rst;
        wbin_d     = wbin_q + {{(PTR_W-1){1'b0}}, accept};
        wgray_d    = wbin_d ^ (wbin_d >> 1);
        count_d    = count_q + {5'd0, accept};
        // Modular subtraction keeps the level correct across the pointer wrap.
        level_d    = wbin_d - rbin;
        wfull_d    = (level_d == PTR_W'(DEPTH));
        afull_d    = (afull_value != '0) && (level_d >= {1'b0, afull_value});
        overflow_d = write_enable & wfull_q & ~sw_rst;
    end

    always_ff @(posedge wclk) begin
        if (sw_rst) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            level_q    <= '0;
            count_q    <= '0;
            wfull_q    <= 1'b0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            level_q    <= level_d;
            count_q    <= count_d;
            wfull_q    <= wfull_d;
            afull_q    <= afull_d;
            overflow_q <= overflow_d;
        end
    end

    assign mem_we           = accept;
    assign waddr            = wbin_q[ADDR_W-1:0];
    assign wgray            = wgray_q;
    assign wfull            = wfull_q;
    assign wr_almost_ful    = afull_q;
    assign overflow         = overflow_q;
    assign fifo_write_count = count_q;
    assign wr_level         = level_q;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Bench for fifo_wr_ptr_ctrl: directed scenarios plus randomized traffic against an
// occupancy model of the write side.
module tb_fifo_wr_ptr_ctrl;

    logic       wclk = 1'b0;
    logic       sw_rst = 1'b1;
    logic       write_enable = 1'b0;
    logic [4:0] afull_value = 5'd0;
    logic [5:0] rgray_sync;
    logic       mem_we;
    logic [4:0] waddr;
    logic [5:0] wgray;
    logic       wfull;
    logic       wr_almost_ful;
    logic       overflow;
    logic [5:0] fifo_write_count;
    logic [5:0] wr_level;

    int rptr = 0;
    int checks = 0;
    int failures = 0;

    always #5 wclk = ~wclk;

    assign rgray_sync = 6'(((rptr % 64) ^ ((rptr % 64) >> 1)));

    fifo_wr_ptr_ctrl #(.DEPTH(32), .ADDR_W(5), .PTR_W(6)) dut (
        .wclk             (wclk),
        .sw_rst           (sw_rst),
        .write_enable     (write_enable),
        .afull_value      (afull_value),
        .rgray_sync       (rgray_sync),
        .mem_we           (mem_we),
        .waddr            (waddr),
        .wgray            (wgray),
        .wfull            (wfull),
        .wr_almost_ful    (wr_almost_ful),
        .overflow         (overflow),
        .fifo_write_count (fifo_write_count),
        .wr_level         (wr_level)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: write pointer as an entry count, occupancy = writes minus reads.
    int  m_wbin = 0;
    int  m_count = 0;
    int  m_level = 0;
    bit  m_full = 0;
    bit  m_af = 0;
    bit  m_ovf = 0;
    bit  m_valid = 0;
    bit  m_rst_edge = 0;

    always @(posedge wclk) begin
        bit acc;
        int lvl;
        acc = write_enable && !m_full && !sw_rst;
        m_rst_edge = sw_rst;
        if (sw_rst) begin
            m_wbin = 0; m_count = 0; m_level = 0;
            m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            m_ovf = write_enable && m_full;
            if (acc) begin
                m_wbin  = (m_wbin + 1) % 64;
                m_count = (m_count + 1) % 64;
            end
            lvl     = ((m_wbin - (rptr % 64)) % 64 + 64) % 64;
            m_level = lvl;
            m_full  = (lvl == 32);
            m_af    = (afull_value != 0) && (lvl >= int'(afull_value));
        end
        m_valid = 1;
    end

    logic [5:0] prev_g = '0;

    always @(negedge wclk) begin
        if (m_valid) begin
            chk("mem_we", int'(mem_we), int'(write_enable && !m_full && !sw_rst));
            chk("waddr", int'(waddr), m_wbin % 32);
            chk("wgray", int'(wgray), m_wbin ^ (m_wbin >> 1));
            chk("wfull", int'(wfull), int'(m_full));
            chk("almost_full", int'(wr_almost_ful), int'(m_af));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("write_count", int'(fifo_write_count), m_count);
            chk("wr_level", int'(wr_level), m_level);
            if (!m_rst_edge && wgray != prev_g)
                chk("wgray_one_bit", $countones(wgray ^ prev_g), 1);
            prev_g = wgray;
        end
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        sw_rst = 1'b1;
        write_enable = 1'b0;
        rptr = 0;
        tick();
        sw_rst = 1'b0;
    endtask

    initial begin
        int ovfn;
        int occ;
        int rd_pct;

        // 1. Reset values and full fill
        do_reset();
        chk("rst_wgray", int'(wgray), 0);
        chk("rst_wfull", int'(wfull), 0);
        chk("rst_level", int'(wr_level), 0);
        chk("rst_count", int'(fifo_write_count), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_afull", int'(wr_almost_ful), 0);
        chk("rst_waddr", int'(waddr), 0);
        write_enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("fill_waddr", int'(waddr), i);
            chk("fill_mem_we", int'(mem_we), 1);
            tick();
        end
        chk("fill_wfull", int'(wfull), 1);
        chk("fill_level", int'(wr_level), 32);
        chk("fill_count", int'(fifo_write_count), 32);

        // 2. Overflow: three rejected requests
        ovfn = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ovf_mem_we", int'(mem_we), 0);
            tick();
            if (overflow) ovfn++;
        end
        write_enable = 1'b0;
        tick();
        chk("ovf_cycles", ovfn, 3);
        chk("ovf_not_sticky", int'(overflow), 0);
        chk("ovf_level", int'(wr_level), 32);
        chk("ovf_count", int'(fifo_write_count), 32);

        // 3. Almost-full threshold
        do_reset();
        afull_value = 5'd28;
        write_enable = 1'b1;
        repeat (27) tick();
        chk("af_below", int'(wr_almost_ful), 0);
        tick();
        chk("af_rise", int'(wr_almost_ful), 1);
        write_enable = 1'b0;
        rptr = 1;
        tick();
        chk("af_fall", int'(wr_almost_ful), 0);
        chk("af_level27", int'(wr_level), 27);
        afull_value = 5'd0;
        write_enable = 1'b1;
        repeat (5) tick();
        write_enable = 1'b0;
        tick();
        chk("af0_full", int'(wfull), 1);
        chk("af0_off", int'(wr_almost_ful), 0);

        // 4. Drain from full with rgray_sync = 7
        do_reset();
        write_enable = 1'b1;
        repeat (32) tick();
        write_enable = 1'b0;
        rptr = 5;
        #1;
        chk("drain_rgray", int'(rgray_sync), 7);
        tick();
        chk("drain_wfull", int'(wfull), 0);
        chk("drain_level", int'(wr_level), 27);
        write_enable = 1'b1;
        #1;
        chk("drain_accept", int'(mem_we), 1);
        chk("drain_waddr", int'(waddr), 0);
        tick();
        write_enable = 1'b0;
        chk("drain_level28", int'(wr_level), 28);

        // 5. Wrap with level held at 4
        do_reset();
        write_enable = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 70; i++) begin
            rptr++;
            tick();
        end
        write_enable = 1'b0;
        chk("wrap_level", int'(wr_level), 4);
        chk("wrap_count", int'(fifo_write_count), 10);

        // 6. Mid-burst reset
        write_enable = 1'b1;
        repeat (5) tick();
        sw_rst = 1'b1;
        rptr = 0;
        #1;
        chk("midrst_mem_we", int'(mem_we), 0);
        tick();
        sw_rst = 1'b0;
        chk("midrst_overflow", int'(overflow), 0);
        chk("midrst_wfull", int'(wfull), 0);
        chk("midrst_level", int'(wr_level), 0);
        chk("midrst_count", int'(fifo_write_count), 0);
        chk("midrst_wgray", int'(wgray), 0);
        chk("midrst_waddr", int'(waddr), 0);

        // Randomized traffic; read pointer only advances over written entries
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rd_pct = ((c / 500) % 2 == 1) ? 85 : 40;
            write_enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) afull_value = 5'($urandom_range(0, 31));
            occ = ((m_wbin - (rptr % 64)) % 64 + 64) % 64;
            if (occ > 0 && $urandom_range(0, 99) < rd_pct) rptr++;
            if ($urandom_range(0, 299) == 0) begin
                sw_rst = 1'b1;
                rptr = 0;
            end else begin
                sw_rst = 1'b0;
            end
            tick();
        end
        sw_rst = 1'b0;
        write_enable = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ptr_ctrl.md
Name: fifo_wr_ptr_ctrl

Overview:
Write-domain pointer and status controller of the async FIFO. It sits directly behind the write interface, sits in front of the dual-port memory, and receives the read pointer from the read-domain CDC.
It consumes write_enable and afull_value, and it produces the memory write strobe and address, the Gray write pointer (exported to the read domain), and every write-side status signal: wfull, wr_almost_ful, overflow, fifo_write_count and wr_level.
All logic runs on wclk.

Parameters:
DEPTH, 32, FIFO entries; must be a power of two.
ADDR_W, 5, memory address width; equals log2(DEPTH).
PTR_W, 6, pointer width; equals ADDR_W+1, with one extra wrap bit.

Ports:
wclk  input  1  write-domain clock.
sw_rst  input  1  synchronous, active-high reset; sampled on posedge wclk.
write_enable  input  1  write request from the write interface.
afull_value  input  ADDR_W  almost-full threshold in entries.
rgray_sync  input  PTR_W  read pointer in Gray code, already 2-FF synchronized into wclk.
mem_we  output  1  memory write strobe.
waddr  output  ADDR_W  memory write address.
wgray  output  PTR_W  registered Gray write pointer, sent to the read domain.
wfull  output  1  FIFO full.
wr_almost_ful  output  1  level has reached afull_value.
overflow  output  1  rejected-write pulse.
fifo_write_count  output  6  accepted writes since reset.
wr_level  output  6  occupancy as seen from the write domain, range 0..DEPTH.

Behaviour:
- One clock (wclk). Reset is synchronous and active-high (sw_rst) and has priority over all other activity.
- Values on reset: wbin=0, wgray=0, wfull=0, wr_almost_ful=0, overflow=0, fifo_write_count=0, wr_level=0. mem_we is 0 in every cycle where sw_rst=1.
- accept = write_enable & ~wfull & ~sw_rst. mem_we = accept, combinational.
- waddr = wbin[ADDR_W-1:0], combinational from the register. The memory captures the data at the same posedge.
- On accept: wbin <= wbin+1 modulo 2^PTR_W, and wgray <= bin2gray(wbin+1) on the same edge. wgray is always registered and changes by exactly one bit per accept.
- rbin = gray2bin(rgray_sync), combinational. rgray_sync is not re-synchronized inside this block.
- Definitions: wbin_next = wbin + accept; level_next = (wbin_next - rbin) mod 2^PTR_W.
- Registered each cycle from level_next:
  - wr_level <= level_next
  - wfull <= (level_next == DEPTH); equivalently, bin2gray(wbin_next) equals rgray_sync with its two MSBs inverted
  - wr_almost_ful <= (afull_value != 0) & (level_next >= afull_value)
- Latency: an accept in cycle N is reflected in wr_level, wfull and wr_almost_ful in cycle N+1.
- A change on rgray_sync in cycle N is reflected in cycle N+1.
- Simultaneous accept and read-pointer change: both enter level_next in the same cycle.
- Full is pessimistic. wfull clears only once the synchronized read pointer shows space; stale rgray_sync can never produce an overwrite.
- overflow <= write_enable & wfull & ~sw_rst. It is a one-cycle pulse per rejected request, not sticky, and a rejected request leaves pointers and count unchanged.
- fifo_write_count increments by 1 per accept and wraps 63->0.
- Pointer wrap 63->0 is handled by the modular subtraction; wr_level stays correct across the wrap.
- afull_value may change at any time; the new threshold takes effect on the next edge.
- sw_rst asserted mid-burst: the next edge produces all reset values, the write in that cycle is dropped, and no overflow is flagged.
- rgray_sync changing by more than one bit per cycle is illegal input; behaviour is undefined and is not checked.

Test Plan:
1. Full fill: reset, rgray_sync=0, write_enable=1 for 32 cycles.
   Required: waddr steps 0..31 with mem_we=1; wfull=1 and wr_level=32 in the cycle after the 32nd accept; fifo_write_count=32.
2. Overflow: with the FIFO full, write_enable=1 for 3 cycles.
   Required: mem_we=0 throughout; overflow high for exactly 3 cycles, one cycle delayed; wr_level=32 and fifo_write_count=32 unchanged.
3. Almost-full threshold: afull_value=28, write 28 entries.
   Required: wr_almost_ful rises the cycle after the 28th accept and falls when the level drops to 27.
   With afull_value=0, wr_almost_ful stays 0 even when full.
4. Drain: from full, drive rgray_sync=7 (Gray code of 5).
   Required: next cycle wfull=0 and wr_level=27; a write in that cycle is accepted with waddr=0.
5. Wrap: stream writes while advancing rgray_sync to hold the level at 4 until wbin passes 63->0.
   Required: each wgray step changes exactly one bit; wr_level stays 4; fifo_write_count wraps 63->0.
6. Mid-burst reset: sw_rst=1 for 1 cycle during writes with write_enable=1.
   Required: mem_we=0 in that cycle; next cycle all outputs are 0, waddr=0 and overflow=0.
